// File: rtl/int_ascii_pkg.sv
// int_ascii_pkg: shared types, ASCII constants and sizing helpers
// for the integer-to-ASCII byte stream converter.
package int_ascii_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_CONVERT,
      S_PAD,
      S_SIGN,
      S_PREFIX,
      S_DIGITS,
      S_SEP,
      S_FINISH
   } state_t;

   localparam logic [7:0] ASC_ZERO  = 8'h30;
   localparam logic [7:0] ASC_MINUS = 8'h2D;
   localparam logic [7:0] ASC_SPACE = 8'h20;
   localparam logic [7:0] ASC_A     = 8'h41;
   localparam logic [7:0] ASC_X     = 8'h78;

   // ceil(width * log10(2)) in fixed point
   function automatic int dec_digits(input int width);
      return (width * 30103 + 99999) / 100000;
   endfunction

   function automatic logic [7:0] digit_ascii(input logic [3:0] d);
      if (d < 4'd10)
         return ASC_ZERO + {4'd0, d};
      return ASC_A + {4'd0, d} - 8'd10;
   endfunction

endpackage

// File: rtl/udiv10_step.sv
// udiv10_step: combinational unsigned divide-by-10.
// Ports: num (dividend) -> quo (quotient), rem (4-bit remainder).
module udiv10_step
   import int_ascii_pkg::*;
#(
   parameter int DATA_WIDTH = 32
) (
   input  logic [DATA_WIDTH-1:0] num,
   output logic [DATA_WIDTH-1:0] quo,
   output logic [3:0]            rem
);

   logic [DATA_WIDTH-1:0] prod;
   logic [DATA_WIDTH-1:0] diff;
   logic                  unused_hi;

   assign quo  = num / DATA_WIDTH'(10);
   assign prod = quo * DATA_WIDTH'(10);
   assign diff = num - prod;
   assign rem  = diff[3:0];

   // remainder is always < 10, upper bits are zero
   assign unused_hi = |diff[DATA_WIDTH-1:4];

endmodule

// File: rtl/int_to_ascii_stream.sv
// int_to_ascii_stream: converts a DATA_WIDTH integer into an ASCII byte
// stream (sign, space padding, optional separator, last marker).
// Ports: clk, rst (sync, active high); in_valid/in_ready/in_data/
// in_signed/in_sep_en/in_hex word input; char_data/char_valid/
// char_last/char_ready byte output; busy, done status.
// Optional: define INT_TO_ASCII_HEX_EN for in_hex radix-16 with "0x".
module int_to_ascii_stream
   import int_ascii_pkg::*;
#(
   parameter int         DATA_WIDTH  = 32,
   parameter int         FIELD_WIDTH = 0,
   parameter logic [7:0] SEP_CHAR    = 8'h20
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DATA_WIDTH-1:0] in_data,
   input  logic                  in_signed,
   input  logic                  in_sep_en,
   input  logic                  in_hex,
   output logic [7:0]            char_data,
   output logic                  char_valid,
   output logic                  char_last,
   input  logic                  char_ready,
   output logic                  busy,
   output logic                  done
);

   localparam int MAX_DIGITS = dec_digits(DATA_WIDTH);
   localparam int MAX_CHARS  = MAX_DIGITS + 1;
   localparam int FW = (FIELD_WIDTH > MAX_CHARS) ? MAX_CHARS : FIELD_WIDTH;
`ifdef INT_TO_ASCII_HEX_EN
   localparam int HEX_DIGITS = (DATA_WIDTH + 3) / 4;
   localparam int DEPTH = (MAX_DIGITS > HEX_DIGITS) ? MAX_DIGITS : HEX_DIGITS;
`else
   localparam int DEPTH = MAX_DIGITS;
`endif
   localparam int IW = $clog2(DEPTH + 1);

   state_t                state;
   logic [DATA_WIDTH-1:0] mag;
   logic                  neg_q;
   logic                  sep_q;
   logic                  hex_q;
   logic                  conv_fin;
   logic                  pfx_q;
   logic [IW-1:0]         ptr;
   logic [IW-1:0]         top_idx;
   logic [7:0]            pad_cnt;
   logic [3:0]            stk [0:(2**IW)-1];

   // magnitude of the incoming word, negation in DATA_WIDTH+1 bits so
   // the most-negative value yields 2^(DATA_WIDTH-1)
   logic [DATA_WIDTH:0]   in_ext;
   logic [DATA_WIDTH:0]   in_negd;
   logic                  in_neg;
   logic [DATA_WIDTH-1:0] in_mag;
   logic                  unused_nb;

   assign in_ext    = {in_data[DATA_WIDTH-1], in_data};
   assign in_negd   = -in_ext;
   assign in_neg    = in_signed & in_data[DATA_WIDTH-1];
   assign in_mag    = in_neg ? in_negd[DATA_WIDTH-1:0] : in_data;
   assign unused_nb = in_negd[DATA_WIDTH];

   logic [DATA_WIDTH-1:0] q10;
   logic [3:0]            r10;
   logic [DATA_WIDTH-1:0] nxt_mag;
   logic [3:0]            dig;
   logic                  conv_last;

   udiv10_step #(.DATA_WIDTH(DATA_WIDTH)) u_div (
      .num (mag),
      .quo (q10),
      .rem (r10)
   );

`ifdef INT_TO_ASCII_HEX_EN
   always_comb begin
      if (hex_q) begin
         dig       = mag[3:0];
         nxt_mag   = mag >> 4;
         conv_last = mag < DATA_WIDTH'(16);
      end else begin
         dig       = r10;
         nxt_mag   = q10;
         conv_last = mag < DATA_WIDTH'(10);
      end
   end
`else
   logic unused_hex;
   assign unused_hex = in_hex;
   assign hex_q      = 1'b0;
   assign dig        = r10;
   assign nxt_mag    = q10;
   assign conv_last  = mag < DATA_WIDTH'(10);
`endif

   logic [7:0] used;
   logic [7:0] pad_calc;
   state_t     after_pad;
   state_t     after_sign;

   assign used     = 8'(ptr) + {7'd0, neg_q} + (hex_q ? 8'd2 : 8'd0);
   assign pad_calc = (8'(FW) > used) ? 8'(FW) - used : 8'd0;

   assign after_sign = hex_q ? S_PREFIX : S_DIGITS;
   assign after_pad  = neg_q ? S_SIGN : after_sign;

   assign top_idx = ptr - IW'(1);

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= S_IDLE;
         mag      <= '0;
         neg_q    <= 1'b0;
         sep_q    <= 1'b0;
         conv_fin <= 1'b0;
         pfx_q    <= 1'b0;
         ptr      <= '0;
         pad_cnt  <= '0;
`ifdef INT_TO_ASCII_HEX_EN
         hex_q    <= 1'b0;
`endif
      end else begin
         unique case (state)
            S_IDLE: begin
               if (in_valid) begin
                  mag      <= in_mag;
                  neg_q    <= in_neg;
                  sep_q    <= in_sep_en;
                  conv_fin <= 1'b0;
                  pfx_q    <= 1'b0;
                  ptr      <= '0;
`ifdef INT_TO_ASCII_HEX_EN
                  hex_q    <= in_hex;
`endif
                  state    <= S_CONVERT;
               end
            end
            S_CONVERT: begin
               // one digit per cycle, then one cycle to size the field
               if (!conv_fin) begin
                  ptr      <= ptr + IW'(1);
                  mag      <= nxt_mag;
                  conv_fin <= conv_last;
               end else begin
                  pad_cnt <= pad_calc;
                  state   <= (pad_calc != 8'd0) ? S_PAD : after_pad;
               end
            end
            S_PAD: begin
               if (char_ready) begin
                  pad_cnt <= pad_cnt - 8'd1;
                  if (pad_cnt == 8'd1)
                     state <= after_pad;
               end
            end
            S_SIGN: begin
               if (char_ready)
                  state <= after_sign;
            end
            S_PREFIX: begin
               if (char_ready) begin
                  pfx_q <= 1'b1;
                  if (pfx_q)
                     state <= S_DIGITS;
               end
            end
            S_DIGITS: begin
               if (char_ready) begin
                  ptr <= top_idx;
                  if (ptr == IW'(1))
                     state <= sep_q ? S_SEP : S_FINISH;
               end
            end
            S_SEP: begin
               if (char_ready)
                  state <= S_FINISH;
            end
            S_FINISH: state <= S_IDLE;
            default:  state <= S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (state == S_CONVERT && !conv_fin)
         stk[ptr] <= dig;
   end

   always_comb begin
      char_valid = 1'b0;
      char_data  = 8'h00;
      char_last  = 1'b0;
      unique case (state)
         S_PAD: begin
            char_valid = 1'b1;
            char_data  = ASC_SPACE;
         end
         S_SIGN: begin
            char_valid = 1'b1;
            char_data  = ASC_MINUS;
         end
         S_PREFIX: begin
            char_valid = 1'b1;
            char_data  = pfx_q ? ASC_X : ASC_ZERO;
         end
         S_DIGITS: begin
            char_valid = 1'b1;
            char_data  = digit_ascii(stk[top_idx]);
            char_last  = (ptr == IW'(1)) && !sep_q;
         end
         S_SEP: begin
            char_valid = 1'b1;
            char_data  = SEP_CHAR;
            char_last  = 1'b1;
         end
         default: ;
      endcase
   end

   assign in_ready = (state == S_IDLE);
   assign busy     = (state != S_IDLE) && (state != S_FINISH);
   assign done     = (state == S_FINISH);

endmodule

// File: tb/tb_int_to_ascii_stream.sv
// tb_int_to_ascii_stream: scoreboard bench, two DUT configurations
// (32-bit no padding, 64-bit field width 6), random and directed words.
module tb_int_to_ascii_stream;

   logic clk;
   logic rst;

   logic        a_val, a_ir, a_sgn, a_sep, a_hex;
   logic [31:0] a_data;
   logic [7:0]  a_cd;
   logic        a_cv, a_cl, a_cr, a_busy, a_done;

   logic        b_val, b_ir, b_sgn, b_sep, b_hex;
   logic [63:0] b_data;
   logic [7:0]  b_cd;
   logic        b_cv, b_cl, b_cr, b_busy, b_done;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   logic [8:0] qa [$];
   logic [8:0] qb [$];
   int         la [$];
   int         lb [$];

   bit         stall [2];
   logic [8:0] hold [2];
   bit         exp_done [2];
   bit         first [2];

   int_to_ascii_stream #(.DATA_WIDTH(32), .FIELD_WIDTH(0)) dut_a (
      .clk(clk), .rst(rst),
      .in_valid(a_val), .in_ready(a_ir), .in_data(a_data),
      .in_signed(a_sgn), .in_sep_en(a_sep), .in_hex(a_hex),
      .char_data(a_cd), .char_valid(a_cv), .char_last(a_cl),
      .char_ready(a_cr), .busy(a_busy), .done(a_done)
   );

   int_to_ascii_stream #(.DATA_WIDTH(64), .FIELD_WIDTH(6)) dut_b (
      .clk(clk), .rst(rst),
      .in_valid(b_val), .in_ready(b_ir), .in_data(b_data),
      .in_signed(b_sgn), .in_sep_en(b_sep), .in_hex(b_hex),
      .char_data(b_cd), .char_valid(b_cv), .char_last(b_cl),
      .char_ready(b_cr), .busy(b_busy), .done(b_done)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      a_cr = 1'b1;
      b_cr = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         a_cr = ($urandom % 4) != 0;
         b_cr = ($urandom % 3) != 0;
      end
   end

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s act=%h exp=%h t=%0t", nm, act, exp, $time);
      end
   endtask

   // expected text: decimal magnitude, leading minus, left space
   // padding to the field width, trailing separator
   function automatic void render(input logic [63:0] v, input int dw,
                                  input bit sgn, input bit sep,
                                  input int fw, output string s,
                                  output int n);
      logic [63:0] mask;
      logic [63:0] m;
      bit          neg;
      string       d;
      mask = (dw == 64) ? '1 : ((64'd1 << dw) - 64'd1);
      m    = v & mask;
      neg  = sgn && m[dw-1];
      if (neg) m = (~m + 64'd1) & mask;
      d = $sformatf("%0d", m);
      n = d.len();
      s = d;
      if (neg) s = {"-", s};
      while (s.len() < fw) s = {" ", s};
      if (sep) s = {s, " "};
   endfunction

   task automatic send(input int k, input logic [63:0] d, input bit s,
                       input bit sep);
      string      str;
      int         n;
      int         t;
      int         acc;
      logic [8:0] e;
      render(d, k ? 64 : 32, s, sep, k ? 6 : 0, str, n);
      @(negedge clk);
      if (k == 0) begin
         a_data = d[31:0]; a_sgn = s; a_sep = sep; a_val = 1'b1;
      end else begin
         b_data = d; b_sgn = s; b_sep = sep; b_val = 1'b1;
      end
      t = 0;
      while (!(k == 0 ? a_ir : b_ir) && t < 1000) begin
         @(negedge clk);
         t++;
      end
      if (t >= 1000) begin
         total++;
         bad++;
         $display("FAIL accept_timeout dut=%0d", k);
      end else begin
         acc = cyc + 1;
         for (int i = 0; i < str.len(); i++) begin
            e = {(i == str.len() - 1), str[i]};
            if (k == 0) qa.push_back(e);
            else        qb.push_back(e);
         end
         if (k == 0) la.push_back(acc + n + 1);
         else        lb.push_back(acc + n + 1);
      end
      @(posedge clk);
      #1;
      if (k == 0) a_val = 1'b0;
      else        b_val = 1'b0;
   endtask

   task automatic mon(input int k, input logic v, input logic [7:0] d,
                      input logic l, input logic r, input logic dn,
                      input logic bz, input logic ir);
      logic [8:0] e;
      int         el;
      if (rst) begin
         if (k == 0) begin qa.delete(); la.delete(); end
         else        begin qb.delete(); lb.delete(); end
         stall[k]    = 1'b0;
         exp_done[k] = 1'b0;
         first[k]    = 1'b1;
         return;
      end
      if (exp_done[k]) begin
         chk($sformatf("done_pulse%0d", k), 64'(dn), 64'd1);
         exp_done[k] = 1'b0;
      end else begin
         chk($sformatf("no_done%0d", k), 64'(dn), 64'd0);
      end
      if (stall[k])
         chk($sformatf("stall_hold%0d", k), 64'({v, l, d}),
             64'({1'b1, hold[k]}));
      stall[k] = v && !r;
      hold[k]  = {l, d};
      if (v && first[k]) begin
         first[k] = 1'b0;
         if ((k == 0 ? la.size() : lb.size()) == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_word dut=%0d", k);
         end else begin
            el = (k == 0) ? la.pop_front() : lb.pop_front();
            chk($sformatf("latency%0d", k), 64'(cyc), 64'(el));
            chk($sformatf("busy%0d", k), 64'({bz, ir}), 64'd2);
         end
      end
      if (v && r) begin
         if ((k == 0 ? qa.size() : qb.size()) == 0) begin
            total++;
            bad++;
            $display("FAIL extra_byte dut=%0d act=%h", k, d);
         end else begin
            e = (k == 0) ? qa.pop_front() : qb.pop_front();
            chk($sformatf("byte%0d", k), 64'({l, d}), 64'(e));
         end
         if (l) begin
            exp_done[k] = 1'b1;
            first[k]    = 1'b1;
         end
      end
   endtask

   always @(negedge clk) begin
      mon(0, a_cv, a_cd, a_cl, a_cr, a_done, a_busy, a_ir);
      mon(1, b_cv, b_cd, b_cl, b_cr, b_done, b_busy, b_ir);
   end

   initial begin
      #3_000_000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      int          t;
      int          k;
      logic [63:0] d;
      rst = 1'b1;
      a_val = 0; a_sgn = 0; a_sep = 0; a_hex = 0; a_data = '0;
      b_val = 0; b_sgn = 0; b_sep = 0; b_hex = 0; b_data = '0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("reset_a", 64'({a_ir, a_cv, a_cl, a_busy, a_done, a_cd}),
          64'({5'b10000, 8'h00}));
      chk("reset_b", 64'({b_ir, b_cv, b_cl, b_busy, b_done, b_cd}),
          64'({5'b10000, 8'h00}));

      send(0, 64'h0, 1'b1, 1'b0);
      send(0, 64'h8000_0000, 1'b1, 1'b1);
      send(0, 64'h8000_0000, 1'b0, 1'b0);
      send(0, 64'hFFFF_FFFF, 1'b0, 1'b0);
      send(0, 64'hFFFF_FFFF, 1'b1, 1'b1);
      send(1, ~64'd41, 1'b1, 1'b1);
      send(1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b0);
      send(1, 64'h8000_0000_0000_0000, 1'b1, 1'b1);
      send(1, 64'h0, 1'b0, 1'b1);
      send(1, 64'd7, 1'b1, 1'b0);

      repeat (40) begin
         k = $urandom % 2;
         d = {$urandom, $urandom} >> $urandom_range(0, 63);
         send(k, d, 1'($urandom % 2), 1'($urandom % 2));
      end

      t = 0;
      while ((qa.size() != 0 || qb.size() != 0) && t < 20000) begin
         @(negedge clk);
         t++;
      end
      if (t >= 20000) begin
         total++;
         bad++;
         $display("FAIL drain_timeout qa=%0d qb=%0d", qa.size(), qb.size());
      end
      repeat (5) @(negedge clk);

      send(0, 64'hFFFF_FFFF, 1'b0, 1'b1);
      t = 0;
      while (!a_cv && t < 100) begin
         @(negedge clk);
         t++;
      end
      chk("mid_word_valid", 64'(a_cv), 64'd1);
      repeat (2) @(negedge clk);
      @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("rst_mid_a", 64'({a_cv, a_ir, a_done, a_busy, a_cl}),
          64'b01000);
      chk("rst_mid_b", 64'({b_cv, b_ir, b_done}), 64'b010);
      repeat (20) @(negedge clk);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
